// File: rtl/write_size_adapter_pkg.sv
// Shared definitions for the write size adapter: BPF transfer size codes
// and the lane-count helper used to build byte enables.
package write_size_adapter_pkg;

  localparam logic [1:0] BPF_W       = 2'b00;
  localparam logic [1:0] BPF_H       = 2'b01;
  localparam logic [1:0] BPF_B       = 2'b10;
  localparam logic [1:0] BPF_ILLEGAL = 2'b11;

  // Number of byte lanes a transfer occupies; 0 for the illegal code.
  function automatic logic [2:0] bpf_lanes(input logic [1:0] sz);
    case (sz)
      BPF_W:   bpf_lanes = 3'd4;
      BPF_H:   bpf_lanes = 3'd2;
      BPF_B:   bpf_lanes = 3'd1;
      default: bpf_lanes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/write_size_adapter_if.sv
// Request/response bundle between a write requester and the write size
// adapter. The adapter connects through the slave modport.
interface write_size_adapter_if #(
  parameter int PBAW = 12,
  parameter int SFAW = 9
);
  logic [PBAW-1:0] byte_wr_addr;
  logic [1:0]      transfer_sz;
  logic [31:0]     wr_data;
  logic            in_valid;
  logic            in_ready;
  logic [SFAW:0]   word_wr_addra;
  logic [63:0]     bigword_wr;
  logic [7:0]      byte_en;
  logic            out_valid;
  logic            out_ready;
  logic            sz_err;
  logic            len_clr;
  logic [PBAW:0]   pkt_len;

  modport slave (
    input  byte_wr_addr, transfer_sz, wr_data, in_valid, out_ready, len_clr,
    output in_ready, word_wr_addra, bigword_wr, byte_en, out_valid, sz_err, pkt_len
  );

  modport master (
    output byte_wr_addr, transfer_sz, wr_data, in_valid, out_ready, len_clr,
    input  in_ready, word_wr_addra, bigword_wr, byte_en, out_valid, sz_err, pkt_len
  );
endinterface

// File: rtl/write_size_adapter_skid_buffer.sv
// Two-entry skid buffer. ready_o is registered and drops only once both
// entries are occupied, so an upstream push is always accepted when it was
// offered against ready_o. Head entry is presented directly from flops.
module wsa_skid_buffer #(
  parameter int W = 82
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         valid_o,
  input  logic         pop_ready_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, rd_ptr_q, ready_q;
  logic [1:0]   count_q, count_d;
  logic         pop;

  assign valid_o = (count_q != 2'd0);
  assign ready_o = ready_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign pop     = valid_o & pop_ready_i;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q + {1'b0, push_i} - {1'b0, pop};
  end

  // Entry storage, pointers and registered ready; reset flushes both entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
    end
  end

endmodule

// File: rtl/write_size_adapter.sv
// Converts B/H/W big-endian byte writes at any alignment into one 64-bit
// bigword write (word a in [63:32], word a+1 in [31:0]) with byte enables.
// Lanes past the end of packet memory are dropped and flagged in sz_err.
// Optional feature: define WRITE_SIZE_ADAPTER_LEN_TRACK_EN to enable the
// packet length tracker on pkt_len; otherwise pkt_len is tied to 0.
module write_size_adapter
  import write_size_adapter_pkg::*;
#(
  parameter int PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int SNOOP_FWD_ADDR_WIDTH   = 9
) (
  input logic                 clk,
  input logic                 rst_n,
  write_size_adapter_if.slave bus
);

  localparam int PBAW = PACKET_BYTE_ADDR_WIDTH;
  localparam int AW   = SNOOP_FWD_ADDR_WIDTH + 1;
  localparam int PW   = AW + 64 + 8;

  logic [AW-1:0] addra;
  logic [1:0]    off;
  logic [2:0]    lanes;
  logic [7:0]    en_shift, eom_mask, en_ok;
  logic [63:0]   data_sh, bw_ok;
  logic          accept, push, bad_req;
  logic          skid_ready, skid_valid;
  logic [PW-1:0] skid_out;
  logic [AW-1:0] out_addra;
  logic [63:0]   out_bw;
  logic [7:0]    out_en;
  logic          sz_err_q;

  assign addra = bus.byte_wr_addr[PBAW-1:2];
  assign off   = bus.byte_wr_addr[1:0];
  assign lanes = bpf_lanes(bus.transfer_sz);

  // Lane mapping: left-justify the data, shift by the byte offset, then drop
  // lanes that fall in the nonexistent word after the last memory word.
  always_comb begin
    en_shift = ~(8'hFF >> lanes) >> off;
    data_sh  = ({bus.wr_data, 32'h0} << {(3'd4 - lanes), 3'b000}) >> {off, 3'b000};
    eom_mask = (&addra) ? 8'h0F : 8'h00;
    en_ok    = en_shift & ~eom_mask;
    bw_ok    = '0;
    for (int i = 0; i < 8; i++) begin
      if (en_ok[i]) bw_ok[8*i +: 8] = data_sh[8*i +: 8];
    end
    bad_req  = (bus.transfer_sz == BPF_ILLEGAL) | (|(en_shift & eom_mask));
  end

  assign accept = bus.in_valid & skid_ready;
  assign push   = accept & (|en_ok);

  wsa_skid_buffer #(.W(PW)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .data_i      ({addra, bw_ok, en_ok}),
    .ready_o     (skid_ready),
    .valid_o     (skid_valid),
    .pop_ready_i (bus.out_ready),
    .data_o      (skid_out)
  );

  assign {out_addra, out_bw, out_en} = skid_out;
  assign bus.in_ready      = skid_ready;
  assign bus.out_valid     = skid_valid;
  assign bus.word_wr_addra = out_addra;
  assign bus.bigword_wr    = out_bw;
  assign bus.byte_en       = out_en;
  assign bus.sz_err        = sz_err_q;

  // Sticky error flag for illegal sizes and writes running off the end.
  always_ff @(posedge clk) begin
    if (!rst_n)                  sz_err_q <= 1'b0;
    else if (accept && bad_req)  sz_err_q <= 1'b1;
  end

`ifdef WRITE_SIZE_ADAPTER_LEN_TRACK_EN
  logic [2:0]  last_lane;
  logic [PBAW:0] len_cand, pkt_len_q;

  // End address (exclusive) of the write currently at the output.
  always_comb begin
    last_lane = 3'd0;
    for (int l = 0; l < 8; l++) begin
      if (out_en[7-l]) last_lane = 3'(l);
    end
    len_cand = {1'b0, out_addra, 2'b00} + (PBAW+1)'(last_lane) + (PBAW+1)'(1);
  end

  // Running maximum over handed-off writes; a clear wins over an update.
  always_ff @(posedge clk) begin
    if (!rst_n)                 pkt_len_q <= '0;
    else if (bus.len_clr)       pkt_len_q <= '0;
    else if (skid_valid && bus.out_ready && (len_cand > pkt_len_q))
                                pkt_len_q <= len_cand;
  end

  assign bus.pkt_len = pkt_len_q;
`else
  logic unused_len_clr;
  assign unused_len_clr = bus.len_clr;
  assign bus.pkt_len    = '0;
`endif

endmodule

// File: tb/tb_write_size_adapter.sv
module tb_write_size_adapter;
  import write_size_adapter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  write_size_adapter_if bus ();

  write_size_adapter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [9:0]  a;
    logic [63:0] bw;
    logic [7:0]  en;
  } exp_t;

  exp_t        q[$];
  logic        exp_err = 1'b0;
  logic [12:0] exp_len = '0;
  bit          last_edge_rst = 1'b1;
  bit          checking = 1'b0;
  bit          rand_rdy = 1'b0;
  int          handoffs = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: walk the request byte by byte in address order.
  task automatic model_accept(input logic [11:0] addr, input logic [1:0] sz, input logic [31:0] d);
    int   nb, base, ba, lane;
    exp_t e;
    nb = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 0;
    if (sz == 2'b11) exp_err = 1'b1;
    base = int'(addr) & ~3;
    e.a  = addr[11:2];
    e.bw = '0;
    e.en = '0;
    for (int i = 0; i < nb; i++) begin
      ba = int'(addr) + i;
      if (ba >= 4096) exp_err = 1'b1;
      else begin
        lane = ba - base;
        e.en[7-lane] = 1'b1;
        e.bw[63-8*lane -: 8] = d[8*(nb-1-i) +: 8];
      end
    end
    if (e.en != 8'h00) q.push_back(e);
  endtask

  exp_t mon_e;
  int   mon_ml;
  int   mon_c;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_err = 1'b0;
      exp_len = '0;
      last_edge_rst = 1'b1;
    end else begin
      last_edge_rst = 1'b0;
      mon_c = -1;
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        mon_e = q.pop_front();
        handoffs++;
        mon_ml = 0;
        for (int l = 0; l < 8; l++) if (mon_e.en[7-l]) mon_ml = l;
        mon_c = int'(mon_e.a) * 4 + mon_ml + 1;
      end
`ifdef WRITE_SIZE_ADAPTER_LEN_TRACK_EN
      if (bus.len_clr) exp_len = '0;
      else if (mon_c > int'(exp_len)) exp_len = 13'(mon_c);
`endif
      if (bus.in_valid && bus.in_ready)
        model_accept(bus.byte_wr_addr, bus.transfer_sz, bus.wr_data);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(bus.in_ready), last_edge_rst ? 64'd0 : 64'(q.size() < 2));
      if (bus.out_valid && q.size() > 0) begin
        chk("addra", 64'(bus.word_wr_addra), 64'(q[0].a));
        chk("bigword", bus.bigword_wr, q[0].bw);
        chk("byte_en", 64'(bus.byte_en), 64'(q[0].en));
      end
      chk("sz_err", 64'(bus.sz_err), 64'(exp_err));
      chk("pkt_len", 64'(bus.pkt_len), 64'(exp_len));
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [11:0] addr, input logic [1:0] sz, input logic [31:0] d,
                      input bit hold);
    int g;
    bus.byte_wr_addr = addr;
    bus.transfer_sz  = sz;
    bus.wr_data      = d;
    bus.in_valid     = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 100) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 500) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  int          h0;
  logic [11:0] raddr;

  initial begin
    bus.byte_wr_addr = '0;
    bus.transfer_sz  = '0;
    bus.wr_data      = '0;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b1;
    bus.len_clr      = 1'b0;

    @(posedge clk);
    #1;
    checking = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_byte_en", 64'(bus.byte_en), 64'd0);
    chk("rst_bigword", bus.bigword_wr, 64'd0);
    chk("rst_addra", 64'(bus.word_wr_addra), 64'd0);
    chk("rst_sz_err", 64'(bus.sz_err), 64'd0);
    chk("rst_pkt_len", 64'(bus.pkt_len), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    send(12'h005, BPF_W, 32'hAABBCCDD, 1'b0);
    chk("w005_valid", 64'(bus.out_valid), 64'd1);
    chk("w005_addra", 64'(bus.word_wr_addra), 64'd1);
    chk("w005_bigword", bus.bigword_wr, 64'h00AABBCC_DD000000);
    chk("w005_byte_en", 64'(bus.byte_en), 64'h78);
    @(posedge clk);
    #1;

    send(12'h003, BPF_H, 32'h00001234, 1'b0);
    chk("h003_addra", 64'(bus.word_wr_addra), 64'd0);
    chk("h003_bigword", bus.bigword_wr, 64'h00000012_34000000);
    chk("h003_byte_en", 64'(bus.byte_en), 64'h18);
    @(posedge clk);
    #1;

    send(12'h002, BPF_B, 32'h0000005A, 1'b0);
    chk("b002_bigword", bus.bigword_wr, 64'h00005A00_00000000);
    chk("b002_byte_en", 64'(bus.byte_en), 64'h20);
    send(12'h010, BPF_ILLEGAL, 32'hFFFFFFFF, 1'b0);
    chk("illegal_no_write", 64'(bus.out_valid), 64'd0);
    chk("illegal_sz_err", 64'(bus.sz_err), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("sz_err_sticky", 64'(bus.sz_err), 64'd1);
    do_reset();
    chk("sz_err_reset", 64'(bus.sz_err), 64'd0);

    send(12'hFFE, BPF_W, 32'h11223344, 1'b0);
    chk("wffe_addra", 64'(bus.word_wr_addra), 64'h3FF);
    chk("wffe_bigword", bus.bigword_wr, 64'h00001122_00000000);
    chk("wffe_byte_en", 64'(bus.byte_en), 64'h30);
    chk("wffe_sz_err", 64'(bus.sz_err), 64'd1);
    @(posedge clk);
    #1;
    send(12'hFFF, BPF_B, 32'h00000077, 1'b0);
    chk("bfff_bigword", bus.bigword_wr, 64'h00000077_00000000);
    chk("bfff_byte_en", 64'(bus.byte_en), 64'h10);
    @(posedge clk);
    #1;

    do_reset();
    send(12'h010, BPF_W, 32'h01020304, 1'b0);
    send(12'h040, BPF_B, 32'h00000005, 1'b0);
    send(12'h020, BPF_H, 32'h00000607, 1'b0);
    repeat (2) @(posedge clk);
    #1;
`ifdef WRITE_SIZE_ADAPTER_LEN_TRACK_EN
    chk("pkt_len_max", 64'(bus.pkt_len), 64'h041);
`else
    chk("pkt_len_tied", 64'(bus.pkt_len), 64'h0);
`endif
    bus.len_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.len_clr = 1'b0;
    chk("pkt_len_clr", 64'(bus.pkt_len), 64'h0);

    rand_rdy = 1'b1;
    h0 = handoffs;
    for (int i = 0; i < 16; i++) send(12'($urandom), BPF_W, $urandom, 1'b1);
    bus.in_valid = 1'b0;
    drain();
    chk("burst_count", 64'(handoffs - h0), 64'd16);

    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      bus.len_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        raddr = ($urandom_range(0, 3) == 0) ? 12'hFF8 + 12'($urandom_range(0, 7))
                                             : 12'($urandom);
        send(raddr, 2'($urandom_range(0, 3)), $urandom, 1'b1);
      end
    end
    bus.in_valid = 1'b0;
    bus.len_clr  = 1'b0;
    drain();
    rand_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
